// File: rtl/phys_reg_free_list_pkg.sv
// Shared types and sizing for the rename-stage physical register free list.
// Free-list depth is the physical registers left over after architectural mapping.
package phys_reg_free_list_pkg;

    localparam int unsigned WIDTH    = 6;
    localparam int unsigned DEPTH    = 1 << WIDTH;
    localparam int unsigned NUM_ARCH = 32;
    localparam int unsigned FL_DEPTH = DEPTH - NUM_ARCH;
    localparam int unsigned FL_IDX_W = $clog2(FL_DEPTH);
    localparam int unsigned FL_PTR_W = FL_IDX_W + 1;

    typedef logic [WIDTH-1:0]    preg_idx_t;
    typedef logic [FL_IDX_W-1:0] fl_idx_t;
    typedef logic [FL_PTR_W-1:0] fl_ptr_t;

endpackage

// File: rtl/phys_reg_free_list_fl_ptr.sv
// Free-list pointer register: increment, load from snapshot, natural wrap.
// The MSB is the wrap bit; arithmetic simply overflows at the pointer width.
module fl_ptr
    import phys_reg_free_list_pkg::*;
#(
    parameter int unsigned W       = FL_PTR_W,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] ptr_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_o <= RST_VAL;
        end else if (load_i) begin
            ptr_o <= load_val_i;
        end else if (inc_i) begin
            ptr_o <= ptr_o + W'(1);
        end
    end

endmodule

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register indices with one head checkpoint.
// Optional duplicate-release check: define PHYS_FREE_LIST_DUPCHK_EN.
module phys_reg_free_list
    import phys_reg_free_list_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                alloc_req_i,
    output logic                alloc_valid_o,
    output logic [WIDTH-1:0]    alloc_idx_o,
    input  logic                rel_valid_i,
    input  logic [WIDTH-1:0]    rel_idx_i,
    input  logic                ckpt_i,
    input  logic                restore_i,
    output logic [FL_PTR_W-1:0] count_o,
    output logic                overflow_o
);

    preg_idx_t mem [FL_DEPTH];
    fl_ptr_t   head;
    fl_ptr_t   tail;
    fl_ptr_t   ckpt_head;
    logic      empty;
    logic      full;
    logic      alloc_fire;
    logic      rel_fire;
    logic      rel_dup;

    assign count_o       = tail - head;
    assign empty         = (count_o == '0);
    assign full          = (count_o == FL_PTR_W'(FL_DEPTH));
    assign alloc_valid_o = !empty;
    assign alloc_idx_o   = mem[head[FL_IDX_W-1:0]];

    // Restore takes the head path, so a same-cycle alloc must not also advance it.
    assign alloc_fire = alloc_req_i && !empty && !restore_i;
    assign rel_fire   = rel_valid_i && !full && !rel_dup;

    fl_ptr #(
        .W       (FL_PTR_W),
        .RST_VAL ('0)
    ) u_head (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .inc_i      (alloc_fire),
        .load_i     (restore_i),
        .load_val_i (ckpt_head),
        .ptr_o      (head)
    );

    fl_ptr #(
        .W       (FL_PTR_W),
        .RST_VAL (FL_PTR_W'(FL_DEPTH))
    ) u_tail (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .inc_i      (rel_fire),
        .load_i     (1'b0),
        .load_val_i ('0),
        .ptr_o      (tail)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < FL_DEPTH; i++) begin
                mem[i] <= preg_idx_t'(NUM_ARCH + i);
            end
        end else if (rel_fire) begin
            mem[tail[FL_IDX_W-1:0]] <= rel_idx_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ckpt_head  <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (ckpt_i && !restore_i) begin
                ckpt_head <= head;
            end
            if (rel_valid_i && (full || rel_dup)) begin
                overflow_o <= 1'b1;
            end
        end
    end

`ifdef PHYS_FREE_LIST_DUPCHK_EN
    logic [DEPTH-1:0] in_list;
    logic [DEPTH-1:0] alloc_clr;
    logic [DEPTH-1:0] rel_set;
    logic [DEPTH-1:0] restore_set;
    fl_ptr_t          walk_len;
    fl_idx_t          walk_idx;

    assign rel_dup   = rel_valid_i && in_list[rel_idx_i];
    assign alloc_clr = alloc_fire ? (DEPTH'(1) << alloc_idx_o) : '0;
    assign rel_set   = rel_fire ? (DEPTH'(1) << rel_idx_i) : '0;

    // Entries in [ckpt_head, head) are the ones a restore hands back to the list.
    always_comb begin
        restore_set = '0;
        walk_len    = head - ckpt_head;
        walk_idx    = '0;
        for (int unsigned i = 0; i < FL_DEPTH; i++) begin
            walk_idx = ckpt_head[FL_IDX_W-1:0] + FL_IDX_W'(i);
            if (restore_i && (FL_PTR_W'(i) < walk_len)) begin
                restore_set[mem[walk_idx]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                in_list[i] <= (i >= NUM_ARCH);
            end
        end else begin
            in_list <= (in_list & ~alloc_clr) | rel_set | restore_set;
        end
    end
`else
    assign rel_dup = 1'b0;
`endif

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed self-checking bench for phys_reg_free_list.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_phys_reg_free_list;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       alloc_req_i;
    logic       alloc_valid_o;
    logic [5:0] alloc_idx_o;
    logic       rel_valid_i;
    logic [5:0] rel_idx_i;
    logic       ckpt_i;
    logic       restore_i;
    logic [5:0] count_o;
    logic       overflow_o;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk_i = ~clk_i;

    phys_reg_free_list dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .alloc_req_i   (alloc_req_i),
        .alloc_valid_o (alloc_valid_o),
        .alloc_idx_o   (alloc_idx_o),
        .rel_valid_i   (rel_valid_i),
        .rel_idx_i     (rel_idx_i),
        .ckpt_i        (ckpt_i),
        .restore_i     (restore_i),
        .count_o       (count_o),
        .overflow_o    (overflow_o)
    );

    task automatic apply_reset();
        rst_ni      = 1'b0;
        alloc_req_i = 1'b0;
        rel_valid_i = 1'b0;
        rel_idx_i   = '0;
        ckpt_i      = 1'b0;
        restore_i   = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if (alloc_valid_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_valid got %0b want 1", alloc_valid_o);
        end
        tests_run++;
        if (alloc_idx_o !== 6'd32) begin
            tests_failed++;
            $display("FAIL reset_idx got %0d want 32", alloc_idx_o);
        end
        tests_run++;
        if (count_o !== 6'd32) begin
            tests_failed++;
            $display("FAIL reset_count got %0d want 32", count_o);
        end
        tests_run++;
        if (overflow_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_overflow got %0b want 0", overflow_o);
        end
    endtask

    // Drains the whole list from reset state, then tries one more alloc.
    task automatic test_alloc_drain();
        alloc_req_i = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tests_run++;
            if (alloc_idx_o !== 6'(32 + i) || alloc_valid_o !== 1'b1) begin
                tests_failed++;
                $display("FAIL drain_idx[%0d] got idx=%0d valid=%0b want idx=%0d valid=1",
                         i, alloc_idx_o, alloc_valid_o, 32 + i);
            end
            @(negedge clk_i);
        end
        tests_run++;
        if (alloc_valid_o !== 1'b0 || count_o !== 6'd0) begin
            tests_failed++;
            $display("FAIL drain_empty got valid=%0b count=%0d want valid=0 count=0",
                     alloc_valid_o, count_o);
        end
        @(negedge clk_i);
        tests_run++;
        if (alloc_valid_o !== 1'b0 || count_o !== 6'd0) begin
            tests_failed++;
            $display("FAIL drain_extra_req got valid=%0b count=%0d want valid=0 count=0",
                     alloc_valid_o, count_o);
        end
    endtask

    // Continues from empty with alloc_req_i still high: release 7, then 9.
    task automatic test_release_empty();
        alloc_req_i = 1'b1;
        rel_valid_i = 1'b1;
        rel_idx_i   = 6'd7;
        tests_run++;
        if (alloc_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL rel7_no_bypass got valid=%0b want 0", alloc_valid_o);
        end
        @(negedge clk_i);
        tests_run++;
        if (alloc_valid_o !== 1'b1 || alloc_idx_o !== 6'd7 || count_o !== 6'd1) begin
            tests_failed++;
            $display("FAIL rel7_visible got valid=%0b idx=%0d count=%0d want 1/7/1",
                     alloc_valid_o, alloc_idx_o, count_o);
        end
        rel_idx_i = 6'd9;
        @(negedge clk_i);
        tests_run++;
        if (alloc_valid_o !== 1'b1 || alloc_idx_o !== 6'd9 || count_o !== 6'd1) begin
            tests_failed++;
            $display("FAIL rel9_visible got valid=%0b idx=%0d count=%0d want 1/9/1",
                     alloc_valid_o, alloc_idx_o, count_o);
        end
        rel_valid_i = 1'b0;
        @(negedge clk_i);
        tests_run++;
        if (alloc_valid_o !== 1'b0 || count_o !== 6'd0) begin
            tests_failed++;
            $display("FAIL rel_drained got valid=%0b count=%0d want 0/0",
                     alloc_valid_o, count_o);
        end
        alloc_req_i = 1'b0;
    endtask

    // Checkpoint taken in the same cycle as the first of 5 allocs, then restore
    // (with a competing alloc request), then 3 releases into the full list.
    task automatic test_ckpt_restore();
        apply_reset();
        ckpt_i      = 1'b1;
        alloc_req_i = 1'b1;
        @(negedge clk_i);
        ckpt_i = 1'b0;
        repeat (4) @(negedge clk_i);
        tests_run++;
        if (alloc_idx_o !== 6'd37 || count_o !== 6'd27) begin
            tests_failed++;
            $display("FAIL ckpt_after5 got idx=%0d count=%0d want 37/27", alloc_idx_o, count_o);
        end
        restore_i = 1'b1;
        @(negedge clk_i);
        restore_i   = 1'b0;
        alloc_req_i = 1'b0;
        tests_run++;
        if (alloc_idx_o !== 6'd32 || count_o !== 6'd32 || alloc_valid_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL restore got idx=%0d count=%0d valid=%0b want 32/32/1",
                     alloc_idx_o, count_o, alloc_valid_o);
        end
        rel_valid_i = 1'b1;
        rel_idx_i   = 6'd40;
        repeat (3) @(negedge clk_i);
        rel_valid_i = 1'b0;
        tests_run++;
        if (alloc_idx_o !== 6'd32 || count_o !== 6'd32 || overflow_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL restore_rel_dropped got idx=%0d count=%0d ovf=%0b want 32/32/1",
                     alloc_idx_o, count_o, overflow_o);
        end
    endtask

    task automatic test_overflow_sticky();
        apply_reset();
        rel_valid_i = 1'b1;
        rel_idx_i   = 6'd5;
        @(negedge clk_i);
        rel_valid_i = 1'b0;
        tests_run++;
        if (overflow_o !== 1'b1 || count_o !== 6'd32) begin
            tests_failed++;
            $display("FAIL ovf_set got ovf=%0b count=%0d want 1/32", overflow_o, count_o);
        end
        repeat (3) @(negedge clk_i);
        tests_run++;
        if (overflow_o !== 1'b1 || count_o !== 6'd32 || alloc_idx_o !== 6'd32) begin
            tests_failed++;
            $display("FAIL ovf_sticky got ovf=%0b count=%0d idx=%0d want 1/32/32",
                     overflow_o, count_o, alloc_idx_o);
        end
    endtask

    // Two allocs, then one cycle of simultaneous alloc and release of idx 3.
    task automatic test_back_to_back();
        apply_reset();
        alloc_req_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rel_valid_i = 1'b1;
        rel_idx_i   = 6'd3;
        @(negedge clk_i);
        rel_valid_i = 1'b0;
        alloc_req_i = 1'b0;
        tests_run++;
        if (count_o !== 6'd30 || alloc_idx_o !== 6'd35 || overflow_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b got count=%0d idx=%0d ovf=%0b want 30/35/0",
                     count_o, alloc_idx_o, overflow_o);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        alloc_req_i = 1'b1;
        repeat (20) @(negedge clk_i);
        tests_run++;
        if (count_o !== 6'd12 || alloc_idx_o !== 6'd52) begin
            tests_failed++;
            $display("FAIL pre_async got count=%0d idx=%0d want 12/52", count_o, alloc_idx_o);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        tests_run++;
        if (count_o !== 6'd32 || alloc_idx_o !== 6'd32) begin
            tests_failed++;
            $display("FAIL async_reset got count=%0d idx=%0d want 32/32", count_o, alloc_idx_o);
        end
        alloc_req_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        test_reset();
        test_alloc_drain();
        test_release_empty();
        test_ckpt_restore();
        test_overflow_sticky();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
